// File: rtl/lza_lod_pipe_if.sv
// Handshake bundle for the LZA leading-one detector: the upstream string side and
// the downstream count side of one elastic pipeline.
interface lza_lod_pipe_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  string_f;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] lz_count;
  logic                   all_zero;

  // The detector is the slave; the pre-encoder/normalizer side is the master.
  modport slave (
    input  in_valid, string_f, out_ready,
    output in_ready, out_valid, lz_count, all_zero
  );

  modport master (
    output in_valid, string_f, out_ready,
    input  in_ready, out_valid, lz_count, all_zero
  );
endinterface

// File: rtl/lza_lod_pipe.sv
// Two-stage leading-one detector on the LZA indicator string: stage 1 counts each
// half independently, stage 2 merges the halves into the anticipated shift amount.
module lza_lod_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  lza_lod_pipe_if.slave bus
);

  localparam int H = DATA_WIDTH / 2;
  localparam logic [COUNT_WIDTH-1:0] H_CNT = COUNT_WIDTH'(H);

  // Zeros above the highest set bit of one half; H when the half is empty.
  function automatic logic [COUNT_WIDTH-1:0] half_lz(input logic [H-1:0] v);
    logic [COUNT_WIDTH-1:0] cnt;
    cnt = H_CNT;
    for (int i = 0; i < H; i++) begin
      if (v[i]) cnt = COUNT_WIDTH'(H - 1 - i);
    end
    return cnt;
  endfunction

  // Stage 1 state
  logic                   s1_valid_q,   s1_valid_d;
  logic [COUNT_WIDTH-1:0] s1_hi_cnt_q,  s1_hi_cnt_d;
  logic [COUNT_WIDTH-1:0] s1_lo_cnt_q,  s1_lo_cnt_d;
  logic                   s1_hi_zero_q, s1_hi_zero_d;
  logic                   s1_lo_zero_q, s1_lo_zero_d;

  // Stage 2 (output) state
  logic                   out_valid_q,  out_valid_d;
  logic [COUNT_WIDTH-1:0] lz_count_q,   lz_count_d;
  logic                   all_zero_q,   all_zero_d;

  logic s2_ready;
  logic s1_load;
  logic s2_load;

  // Ready ripples backwards combinationally so a full pipe still streams one per cycle.
  assign s2_ready     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_ready;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid_q && s2_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.lz_count  = lz_count_q;
  assign bus.all_zero  = all_zero_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    s1_hi_cnt_d  = half_lz(bus.string_f[DATA_WIDTH-1:H]);
    s1_lo_cnt_d  = half_lz(bus.string_f[H-1:0]);
    s1_hi_zero_d = (bus.string_f[DATA_WIDTH-1:H] == '0);
    s1_lo_zero_d = (bus.string_f[H-1:0] == '0);

    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_ready) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // The upper half wins when it holds a one; otherwise skip it entirely.
    lz_count_d = s1_hi_zero_q ? (H_CNT + s1_lo_cnt_q) : s1_hi_cnt_q;
    all_zero_d = s1_hi_zero_q && s1_lo_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so outputs read as zero rather than X right after reset.
      s1_valid_q   <= 1'b0;
      s1_hi_cnt_q  <= '0;
      s1_lo_cnt_q  <= '0;
      s1_hi_zero_q <= 1'b0;
      s1_lo_zero_q <= 1'b0;
      out_valid_q  <= 1'b0;
      lz_count_q   <= '0;
      all_zero_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so S2 captures the old S1 content on a simultaneous reload.
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s1_load) begin
        s1_hi_cnt_q  <= s1_hi_cnt_d;
        s1_lo_cnt_q  <= s1_lo_cnt_d;
        s1_hi_zero_q <= s1_hi_zero_d;
        s1_lo_zero_q <= s1_lo_zero_d;
      end
      if (s2_load) begin
        lz_count_q <= lz_count_d;
        all_zero_q <= all_zero_d;
      end
    end
  end

endmodule

// File: tb/tb_lza_lod_pipe.sv
// Randomized and directed bench for lza_lod_pipe against a bit-length reference
// model and an in-order scoreboard of accepted strings.
module tb_lza_lod_pipe;
  localparam int DW = 8;
  localparam int CW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lza_lod_pipe_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  lza_lod_pipe #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_lz[$];
  int exp_az[$];
  bit prev_stall = 1'b0;
  int prev_lz    = 0;
  int prev_az    = 0;
  int out_count  = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Leading zeros = width minus the bit length of the value.
  function automatic int ref_lz(input int v);
    int lz = DW;
    int x  = v;
    while (x != 0) begin
      x  = x >> 1;
      lz = lz - 1;
    end
    return lz;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy, output bit acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.string_f  = d;
    bus.out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_lz", int'(bus.lz_count), prev_lz);
      check("hold_az", int'(bus.all_zero), prev_az);
    end
    if (bus.out_valid && ordy) begin
      out_count++;
      check("sb_nonempty", int'(exp_lz.size() > 0), 1);
      if (exp_lz.size() > 0) begin
        check("lz_count", int'(bus.lz_count), exp_lz.pop_front());
        check("all_zero", int'(bus.all_zero), exp_az.pop_front());
      end
    end
    acc = v && bus.in_ready;
    if (acc) begin
      exp_lz.push_back(ref_lz(int'(d)));
      exp_az.push_back(int'(d == '0));
    end
    prev_stall = bus.out_valid && !ordy;
    prev_lz    = int'(bus.lz_count);
    prev_az    = int'(bus.all_zero);
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n = 0;
    while (exp_lz.size() > 0 && n < 40) begin
      cycle(1'b0, '0, 1'b1, acc);
      n++;
    end
    check(tag, exp_lz.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int guard;
    int base;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.string_f  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_lz", int'(bus.lz_count), 0);
    check("rst_az", int'(bus.all_zero), 0);

    // Basic count and two-cycle latency
    cycle(1'b1, 8'b0001_0110, 1'b1, acc);
    check("basic_acc", int'(acc), 1);
    cycle(1'b0, '0, 1'b1, acc);
    check("basic_lat1", int'(bus.out_valid), 0);
    cycle(1'b0, '0, 1'b1, acc);
    check("basic_lat2", int'(bus.out_valid), 1);
    check("basic_lz", int'(bus.lz_count), 3);

    // Boundaries back to back, no bubbles
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] vals [4] = '{8'h80, 8'h01, 8'h00, 8'h08};
      cycle(i < 4, (i < 4) ? vals[i] : '0, 1'b1, acc);
      if (i < 4) check("bnd_acc", int'(acc), 1);
      if (i >= 2) check("bnd_nobubble", int'(bus.out_valid), 1);
    end
    drain("bnd_drain");

    // Backpressure
    cycle(1'b1, 8'h40, 1'b0, acc);
    check("bp_acc1", int'(acc), 1);
    cycle(1'b1, 8'h20, 1'b0, acc);
    check("bp_acc2", int'(acc), 1);
    cycle(1'b1, 8'h10, 1'b0, acc);
    check("bp_acc3_blocked", int'(acc), 0);
    check("bp_in_ready", int'(bus.in_ready), 0);
    check("bp_out_valid", int'(bus.out_valid), 1);
    check("bp_lz_first", int'(bus.lz_count), 1);
    cycle(1'b1, 8'h10, 1'b0, acc);
    check("bp_still_blocked", int'(acc), 0);
    cycle(1'b1, 8'h10, 1'b1, acc);
    check("bp_release_acc", int'(acc), 1);
    cycle(1'b0, '0, 1'b1, acc);
    check("bp_stream2", int'(bus.out_valid), 1);
    drain("bp_drain");

    // Bubbles: gap data must never appear
    cycle(1'b1, 8'h04, 1'b1, acc);
    cycle(1'b0, 8'hFF, 1'b1, acc);
    check("bub_gap_ignored", int'(acc), 0);
    cycle(1'b1, 8'h02, 1'b1, acc);
    drain("bub_drain");

    // Reset while both stages are full
    cycle(1'b1, 8'h40, 1'b0, acc);
    cycle(1'b1, 8'h20, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_lz", int'(bus.lz_count), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    exp_lz.delete();
    exp_az.delete();
    prev_stall = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h02, 1'b1, acc);
    check("post_rst_acc", int'(acc), 1);
    cycle(1'b0, '0, 1'b1, acc);
    check("post_rst_lat1", int'(bus.out_valid), 0);
    cycle(1'b0, '0, 1'b1, acc);
    check("post_rst_lat2", int'(bus.out_valid), 1);
    check("post_rst_lz", int'(bus.lz_count), 6);
    drain("post_rst_drain");

    // Exhaustive sweep with random backpressure
    base = out_count;
    for (int v = 0; v < 256; v++) begin
      guard = 0;
      do begin
        cycle(1'b1, DW'(v), 1'($urandom_range(0, 1)), acc);
        guard++;
      end while (!acc && guard < 50);
      check("exh_accept", int'(acc), 1);
    end
    drain("exh_drain");
    check("exh_count", out_count - base, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
